// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Arbitrates two write-back requesters onto a single register-file write port
// and keeps a scoreboard of registers still awaiting a write from requester B.
//
// Requester A (ALU) normally wins.  Requester B (multi-cycle / load unit) wins
// when A is idle, or once it has been denied MAX_WAIT cycles in a row.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   a_valid / a_ready     requester A handshake
//   a_reg / a_data        requester A destination register / write data
//   b_valid / b_ready     requester B handshake
//   b_reg / b_data        requester B destination register / write data
//   pend_set / pend_reg   decode marks pend_reg as awaiting a B write-back
//   rd_reg1 / rd_reg2     decode source registers
//   stall                 a source register has a pending B write
//   RegWrite / wr_reg / wr_data   registered register-file write port
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [4:0]  a_reg,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_reg,
    input  logic [31:0] b_data,
    input  logic        pend_set,
    input  logic [4:0]  pend_reg,
    input  logic [4:0]  rd_reg1,
    input  logic [4:0]  rd_reg2,
    output logic        stall,
    output logic        RegWrite,
    output logic [4:0]  wr_reg,
    output logic [31:0] wr_data
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic [3:0]  wait_cnt_r;
    logic [3:0]  wait_cnt_nxt_s;
    logic [31:0] pend_r;
    logic [31:0] pend_nxt_s;
    logic        a_fire_s;
    logic        b_fire_s;

    // Register 0 is hard-wired, so it can never be a pending hazard.
    function automatic logic src_pending(input logic [4:0] r, input logic [31:0] p);
        return (r != 5'd0) && p[r];
    endfunction

    // Grant selection: A by default, B when A idle or B has starved MAX_WAIT cycles.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (b_valid && (wait_cnt_r == MAX_WAIT_C)) begin
            a_ready = 1'b0;
            b_ready = 1'b1;
        end else begin
            a_ready = a_valid;
            b_ready = b_valid && !a_valid;
        end
    end

    assign a_fire_s = a_valid && a_ready;
    assign b_fire_s = b_valid && b_ready;

    // Starvation counter: counts consecutive denied B cycles, saturating.
    always_comb begin
        wait_cnt_nxt_s = 4'd0;
        if (b_valid && !b_ready) begin
            if (wait_cnt_r < MAX_WAIT_C) begin
                wait_cnt_nxt_s = wait_cnt_r + 4'd1;
            end else begin
                wait_cnt_nxt_s = wait_cnt_r;
            end
        end else begin
            wait_cnt_nxt_s = 4'd0;
        end
    end

    // Scoreboard next state: B write-back clears, decode set applied last so it wins.
    always_comb begin
        pend_nxt_s = pend_r;
        if (b_fire_s) begin
            pend_nxt_s[b_reg] = 1'b0;
        end else begin
            pend_nxt_s = pend_r;
        end
        if (pend_set && (pend_reg != 5'd0)) begin
            pend_nxt_s[pend_reg] = 1'b1;
        end else begin
            pend_nxt_s[0] = 1'b0;
        end
        pend_nxt_s[0] = 1'b0;
    end

    // Decode hazard check against the current scoreboard.
    always_comb begin
        stall = src_pending(rd_reg1, pend_r) || src_pending(rd_reg2, pend_r);
    end

    // Arbiter and scoreboard state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= 4'd0;
            pend_r     <= 32'd0;
        end else begin
            wait_cnt_r <= wait_cnt_nxt_s;
            pend_r     <= pend_nxt_s;
        end
    end

    // Registered write port; a register-0 transfer handshakes but suppresses the write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWrite <= 1'b0;
            wr_reg   <= 5'd0;
            wr_data  <= 32'd0;
        end else if (a_fire_s) begin
            RegWrite <= (a_reg != 5'd0);
            wr_reg   <= a_reg;
            wr_data  <= a_data;
        end else if (b_fire_s) begin
            RegWrite <= (b_reg != 5'd0);
            wr_reg   <= b_reg;
            wr_data  <= b_data;
        end else begin
            RegWrite <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, a_ready;
    logic [4:0]  a_reg;
    logic [31:0] a_data;
    logic        b_valid, b_ready;
    logic [4:0]  b_reg;
    logic [31:0] b_data;
    logic        pend_set;
    logic [4:0]  pend_reg;
    logic [4:0]  rd_reg1, rd_reg2;
    logic        stall;
    logic        RegWrite;
    logic [4:0]  wr_reg;
    logic [31:0] wr_data;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fail_cnt  = 0;

    regfile_wb_arbiter #(.MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
        .pend_set(pend_set), .pend_reg(pend_reg),
        .rd_reg1(rd_reg1), .rd_reg2(rd_reg2), .stall(stall),
        .RegWrite(RegWrite), .wr_reg(wr_reg), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic        bseq [8];
        logic        aexp [8];
        logic [31:0] e;

        rst_n = 1'b0; a_valid = 1'b0; a_reg = 5'd0; a_data = 32'd0;
        b_valid = 1'b0; b_reg = 5'd0; b_data = 32'd0;
        pend_set = 1'b0; pend_reg = 5'd0; rd_reg1 = 5'd5; rd_reg2 = 5'd0;

        // Reset state
        tick(); tick();
        check("rst_regwrite", {31'd0, RegWrite}, 32'd0);
        check("rst_wr_reg", {27'd0, wr_reg}, 32'd0);
        check("rst_wr_data", wr_data, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_a_ready", {31'd0, a_ready}, 32'd0);
        check("rst_b_ready", {31'd0, b_ready}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Single A write
        a_valid = 1'b1; a_reg = 5'd5; a_data = 32'h1234;
        #1;
        check("a1_a_ready", {31'd0, a_ready}, 32'd1);
        check("a1_b_ready", {31'd0, b_ready}, 32'd0);
        tick();
        a_valid = 1'b0;
        check("a1_regwrite", {31'd0, RegWrite}, 32'd1);
        check("a1_wr_reg", {27'd0, wr_reg}, 32'd5);
        check("a1_wr_data", wr_data, 32'h1234);
        tick();
        check("a1_regwrite_off", {31'd0, RegWrite}, 32'd0);
        check("a1_wr_reg_hold", {27'd0, wr_reg}, 32'd5);
        check("a1_wr_data_hold", wr_data, 32'h1234);

        // Both requesting continuously: A,A,A,A,B repeating
        a_valid = 1'b1; b_valid = 1'b1; a_reg = 5'd1; b_reg = 5'd2;
        for (int i = 0; i < 10; i++) begin
            a_data = 32'h100 + 32'(i);
            b_data = 32'h200 + 32'(i);
            #1;
            e = ((i % 5) != 4) ? 32'd1 : 32'd0;
            check("rr_a_ready", {31'd0, a_ready}, e);
            check("rr_b_ready", {31'd0, b_ready}, e ^ 32'd1);
            tick();
            check("rr_regwrite", {31'd0, RegWrite}, 32'd1);
            check("rr_wr_reg", {27'd0, wr_reg}, (e == 32'd1) ? 32'd1 : 32'd2);
            check("rr_wr_data", wr_data, (e == 32'd1) ? 32'h100 + 32'(i) : 32'h200 + 32'(i));
        end
        a_valid = 1'b0; b_valid = 1'b0;
        tick();

        // Scoreboard set, A write leaves it, B write clears it
        pend_set = 1'b1; pend_reg = 5'd7;
        tick();
        pend_set = 1'b0; rd_reg1 = 5'd7;
        #1;
        check("sb_stall_set", {31'd0, stall}, 32'd1);
        a_valid = 1'b1; a_reg = 5'd7; a_data = 32'h77;
        tick();
        a_valid = 1'b0;
        check("sb_a_no_clear", {31'd0, stall}, 32'd1);
        b_valid = 1'b1; b_reg = 5'd7; b_data = 32'hDEAD;
        #1;
        check("sb_b_ready", {31'd0, b_ready}, 32'd1);
        tick();
        b_valid = 1'b0;
        check("sb_stall_clr", {31'd0, stall}, 32'd0);
        check("sb_regwrite", {31'd0, RegWrite}, 32'd1);
        check("sb_wr_reg", {27'd0, wr_reg}, 32'd7);
        check("sb_wr_data", wr_data, 32'hDEAD);

        // Same-cycle set and B clear: set wins
        rd_reg1 = 5'd0; rd_reg2 = 5'd9;
        pend_set = 1'b1; pend_reg = 5'd9;
        b_valid = 1'b1; b_reg = 5'd9; b_data = 32'h99;
        #1;
        check("sc_stall_before", {31'd0, stall}, 32'd0);
        tick();
        pend_set = 1'b0;
        b_valid = 1'b0;
        check("sc_stall_kept", {31'd0, stall}, 32'd1);
        check("sc_wr_reg", {27'd0, wr_reg}, 32'd9);
        b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        check("sc_stall_clr", {31'd0, stall}, 32'd0);

        // Register 0 transfers and pend on register 0
        a_valid = 1'b1; a_reg = 5'd0; a_data = 32'h55;
        #1;
        check("r0_a_ready", {31'd0, a_ready}, 32'd1);
        tick();
        a_valid = 1'b0;
        check("r0_regwrite", {31'd0, RegWrite}, 32'd0);
        pend_set = 1'b1; pend_reg = 5'd0; rd_reg1 = 5'd0; rd_reg2 = 5'd0;
        tick();
        pend_set = 1'b0;
        check("r0_stall", {31'd0, stall}, 32'd0);

        // Wait counter clears when B drops valid
        bseq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        aexp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        a_valid = 1'b1; a_reg = 5'd10; b_reg = 5'd11;
        for (int i = 0; i < 8; i++) begin
            b_valid = bseq[i];
            #1;
            check("wc_a_ready", {31'd0, a_ready}, {31'd0, aexp[i]});
            tick();
        end
        a_valid = 1'b0; b_valid = 1'b0;
        tick();

        // Reset pulse during a B transfer cycle
        a_valid = 1'b1; b_valid = 1'b1; pend_set = 1'b1; pend_reg = 5'd4;
        a_reg = 5'd12; b_reg = 5'd3; rd_reg1 = 5'd4;
        tick();
        pend_set = 1'b0;
        check("rp_stall_pre", {31'd0, stall}, 32'd1);
        tick();
        check("rp_regwrite_pre", {31'd0, RegWrite}, 32'd1);
        a_valid = 1'b0; b_data = 32'h3333;
        #1;
        check("rp_b_ready", {31'd0, b_ready}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rp_regwrite_in_rst", {31'd0, RegWrite}, 32'd0);
        check("rp_stall_in_rst", {31'd0, stall}, 32'd0);
        b_valid = 1'b0;
        #1 rst_n = 1'b1;
        tick();
        check("rp_regwrite_post", {31'd0, RegWrite}, 32'd0);
        check("rp_wr_reg_post", {27'd0, wr_reg}, 32'd0);
        check("rp_stall_post", {31'd0, stall}, 32'd0);
        check("rp_wait_cnt", {28'd0, dut.wait_cnt_r}, 32'd0);

        // First edge after reset accepts a transfer
        a_valid = 1'b1; a_reg = 5'd6; a_data = 32'h66;
        #1;
        check("pr_a_ready", {31'd0, a_ready}, 32'd1);
        tick();
        a_valid = 1'b0;
        check("pr_regwrite", {31'd0, RegWrite}, 32'd1);
        check("pr_wr_reg", {27'd0, wr_reg}, 32'd6);
        check("pr_wr_data", wr_data, 32'h66);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter MAX_WAIT, default 4, SHALL set the number of consecutive denied cycles after which requester B is forced priority; legal range 1..15.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 a_valid / a_ready  input / output  1 / 1  requester A (ALU write-back) handshake.
REQ-005 a_reg / a_data  input  5 / 32  requester A destination register and write data.
REQ-006 b_valid / b_ready  input / output  1 / 1  requester B (multi-cycle unit / load write-back) handshake.
REQ-007 b_reg / b_data  input  5 / 32  requester B destination register and write data.
REQ-008 pend_set / pend_reg  input  1 / 5  decode marks a register as awaiting a B write-back.
REQ-009 rd_reg1 / rd_reg2  input  5 / 5  decode source registers to be checked.
REQ-010 stall  output  1  decode SHALL hold when a source register has a pending B write.
REQ-011 RegWrite / wr_reg / wr_data  output  1 / 5 / 32  register-file write port; all three registered.

Function
REQ-012 Transfer on a requester SHALL occur when its valid and ready are both high on a rising clk edge.
REQ-013 At most one of a_ready and b_ready SHALL be high in any cycle; each ready SHALL be combinational from current valids and the wait counter, with no dependence on the same cycle's ready.
REQ-014 Default priority: a_ready = a_valid; b_ready = b_valid && !a_valid.
REQ-015 Forced priority: when wait_cnt == MAX_WAIT and b_valid, b_ready SHALL be 1 and a_ready SHALL be 0.
REQ-016 wait_cnt (4 bits) SHALL increment when b_valid && !b_ready, clear when b_ready or !b_valid, and saturate at MAX_WAIT.
REQ-017 A transfer in cycle N SHALL produce RegWrite=1 in cycle N+1 with the winner's reg/data, latency exactly 1, throughput one write per cycle.
REQ-018 A transfer with destination register 0 SHALL complete the handshake but SHALL leave RegWrite=0 the following cycle.
REQ-019 Without a transfer, RegWrite SHALL be 0 next cycle, and wr_reg/wr_data SHALL hold their previous values.
REQ-020 The scoreboard SHALL be a 32-bit vector pend[31:0]; bit 0 SHALL never be set.
REQ-021 pend_set with pend_reg != 0 SHALL set pend[pend_reg] on the clock edge.
REQ-022 A B transfer SHALL clear pend[b_reg] on the clock edge of the transfer.
REQ-023 When pend_set and a B transfer target the same register in the same cycle, set SHALL win and the bit SHALL remain 1.
REQ-024 A transfers SHALL NOT modify pend.
REQ-025 stall SHALL be combinational: (rd_reg1 != 0 && pend[rd_reg1]) || (rd_reg2 != 0 && pend[rd_reg2]).
REQ-026 If A and B target the same register in consecutive transfers, the register file SHALL receive the writes in grant order; the later write prevails.
REQ-027 Requester inputs SHALL be sampled only at transfer; valid dropping without a transfer SHALL leave no state except the wait_cnt clear.

Reset
REQ-028 While rst_n=0: RegWrite=0, wr_reg=0, wr_data=0, wait_cnt=0, pend=0; consequently stall=0.
REQ-029 Reset asserted mid-operation SHALL discard any in-flight write: no RegWrite pulse in the cycle after release.
REQ-030 After rst_n deasserts, the first rising edge SHALL accept transfers normally.

Verification
REQ-031 a_valid=1, a_reg=5, a_data=0x1234 for one cycle -> a_ready=1 that cycle; next cycle RegWrite=1, wr_reg=5, wr_data=0x1234; the cycle after, RegWrite=0.
REQ-032 a_valid and b_valid held at 1 continuously, MAX_WAIT=4 -> A granted 4 cycles, B granted on the 5th; the pattern repeats every 5 cycles.
REQ-033 pend_set with pend_reg=7, then rd_reg1=7 -> stall=1; B transfer with b_reg=7 -> stall=0 the next cycle and RegWrite=1 with wr_reg=7.
REQ-034 Same-cycle pend_set with pend_reg=9 and a B transfer with b_reg=9 -> pend[9] stays 1, stall stays 1 for rd_reg2=9.
REQ-035 A transfer with a_reg=0 -> a_ready=1, RegWrite=0 next cycle; pend_set with pend_reg=0 -> stall=0 for rd_reg1=0.
REQ-036 rst_n pulsed low in the same cycle as a transfer with b_reg=3 -> RegWrite=0 after release; pend and wait_cnt are zero.
